rpn_stack_calc: RTL and testbench

//  Parametrised Reverse Polish calculator core with a DEPTH-entry operand stack of DATA_W-bit words.

---
 rtl/rpn_stack_calc.sv | 208 ++++++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// Reverse Polish calculator core: DEPTH-entry operand stack, one command per
// rising edge of the debounced Enter level, binary ops through a registered ALU.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a command; pushes and stack ops complete here
// EXEC  | binary op accepted, ALU result and flags being registered
// WB    | pop two operands, push ALU result, update N/Z/C/V
// ERR   | command rejected (overflow/underflow), one cycle then IDLE
module rpn_stack_calc #(
    parameter  int DATA_W  = 16,
    parameter  int DEPTH   = 4,
    localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Enter,
    input  logic               IsOp,
    input  logic [2:0]         OpCode,
    input  logic [DATA_W-1:0]  DataIn,
    output logic [DATA_W-1:0]  ToDisplay,
    output logic [4:0]         Flags,
    output logic [DEPTH_W-1:0] Depth,
    output logic [2:0]         Status
);

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_EXEC = 3'b001;
    localparam logic [2:0] ST_WB   = 3'b010;
    localparam logic [2:0] ST_ERR  = 3'b100;

    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] TWO  = DEPTH_W'(2);
    localparam int                 MSB  = DATA_W - 1;

    logic                enter_q;
    logic                pulse;
    logic [2:0]          state_q, state_d;
    logic [DATA_W-1:0]   stk_q [DEPTH];
    logic [DATA_W-1:0]   stk_d [DEPTH];
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                res_c_q, res_c_d, res_v_q, res_v_d;
    logic                n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic                rej;

    logic [DATA_W-1:0]   alu_r;
    logic                alu_c, alu_v;
    logic [DATA_W:0]     sum_w, dif_w;

    assign pulse = Enter & ~enter_q;

    // ALU on NOS (stk_q[1]) and TOS (stk_q[0]); dif_w[DATA_W] is the borrow
    assign sum_w = {1'b0, stk_q[1]} + {1'b0, stk_q[0]};
    assign dif_w = {1'b0, stk_q[1]} - {1'b0, stk_q[0]};

    // Combinational ALU result and carry/overflow for the latched opcode
    always_comb begin
        alu_r = stk_q[1] ^ stk_q[0];
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_q)
            3'd0: begin
                alu_r = sum_w[DATA_W-1:0];
                alu_c = sum_w[DATA_W];
                alu_v = (stk_q[1][MSB] == stk_q[0][MSB]) && (alu_r[MSB] != stk_q[1][MSB]);
            end
            3'd1: begin
                alu_r = dif_w[DATA_W-1:0];
                alu_c = ~dif_w[DATA_W];
                alu_v = (stk_q[1][MSB] != stk_q[0][MSB]) && (alu_r[MSB] != stk_q[1][MSB]);
            end
            3'd2:    alu_r = stk_q[1] & stk_q[0];
            3'd3:    alu_r = stk_q[1] | stk_q[0];
            default: alu_r = stk_q[1] ^ stk_q[0];
        endcase
    end

    // Command decode, stack manipulation and FSM next state
    always_comb begin
        state_d = state_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        op_d    = op_q;
        res_d   = res_q;
        res_c_d = res_c_q;
        res_v_d = res_v_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        err_d   = err_q;
        rej     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pulse) begin
                    if (!IsOp) begin
                        if (depth_q == FULL) begin
                            rej = 1'b1;
                        end else begin
                            for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                            stk_d[0] = DataIn;
                            depth_d  = depth_q + ONE;
                            err_d    = 1'b0;
                        end
                    end else if (OpCode <= 3'd4) begin
                        if (depth_q >= TWO) begin
                            op_d    = OpCode;
                            err_d   = 1'b0;
                            state_d = ST_EXEC;
                        end else begin
                            rej = 1'b1;
                        end
                    end else if (OpCode == 3'd5) begin
                        if (depth_q != '0 && depth_q != FULL) begin
                            for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                            depth_d = depth_q + ONE;
                            err_d   = 1'b0;
                        end else begin
                            rej = 1'b1;
                        end
                    end else if (OpCode == 3'd6) begin
                        if (depth_q >= TWO) begin
                            stk_d[0] = stk_q[1];
                            stk_d[1] = stk_q[0];
                            err_d    = 1'b0;
                        end else begin
                            rej = 1'b1;
                        end
                    end else begin
                        if (depth_q != '0) begin
                            for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                            stk_d[DEPTH-1] = '0;
                            depth_d        = depth_q - ONE;
                            err_d          = 1'b0;
                        end else begin
                            rej = 1'b1;
                        end
                    end
                    if (rej) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_EXEC: begin
                res_d   = alu_r;
                res_c_d = alu_c;
                res_v_d = alu_v;
                state_d = ST_WB;
            end
            ST_WB: begin
                stk_d[0] = res_q;
                for (int i = 1; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                stk_d[DEPTH-1] = '0;
                depth_d = depth_q - ONE;
                n_d     = res_q[MSB];
                z_d     = (res_q == '0);
                c_d     = res_c_q;
                v_d     = res_v_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
            state_q <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            depth_q <= '0;
            op_q    <= '0;
            res_q   <= '0;
            res_c_q <= 1'b0;
            res_v_q <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            enter_q <= Enter;
            state_q <= state_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            op_q    <= op_d;
            res_q   <= res_d;
            res_c_q <= res_c_d;
            res_v_q <= res_v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    // Live entry is shown while the stack is empty or a number is being keyed in
    assign ToDisplay = (depth_q == '0 || (!IsOp && !Enter)) ? DataIn : stk_q[0];
    assign Flags     = {n_q, z_q, c_q, v_q, err_q};
    assign Depth     = depth_q;
    assign Status    = state_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: queue-based reference stack, scoreboard of expected
// post-command state, monitor that follows each accepted command to completion.
module tb_rpn_stack_calc;

    localparam int DW = 16;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Enter = 1'b0;
    logic          IsOp = 1'b0;
    logic [2:0]    OpCode = 3'd0;
    logic [DW-1:0] DataIn = '0;
    logic [DW-1:0] ToDisplay;
    logic [4:0]    Flags;
    logic [2:0]    Depth;
    logic [2:0]    Status;

    rpn_stack_calc #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .Enter(Enter), .IsOp(IsOp), .OpCode(OpCode),
        .DataIn(DataIn), .ToDisplay(ToDisplay), .Flags(Flags), .Depth(Depth), .Status(Status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] tos;
        int            depth;
        logic [4:0]    flags;
        int            busy;
        logic [2:0]    first;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_stk[$];
    logic          m_n = 0, m_z = 0, m_c = 0, m_v = 0, m_err = 0;
    int            total = 0;
    int            bad = 0;
    logic          mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stack as a queue with TOS at index 0
    function automatic exp_t model(input logic isop, input logic [2:0] op, input logic [DW-1:0] d);
        exp_t          e;
        logic [DW-1:0] a, b, r, t;
        int            s;
        logic          ok;
        e.busy  = 0;
        e.first = 3'b000;
        ok      = 1'b1;
        if (!isop) begin
            if (m_stk.size() == DP) ok = 0;
            else m_stk.push_front(d);
        end else if (op <= 3'd4) begin
            if (m_stk.size() < 2) ok = 0;
            else begin
                b = m_stk.pop_front();
                a = m_stk.pop_front();
                m_c = 0;
                m_v = 0;
                case (op)
                    3'd0: begin
                        r = a + b;
                        m_c = (int'(a) + int'(b)) > 65535;
                        s = int'($signed(a)) + int'($signed(b));
                        m_v = (s > 32767) || (s < -32768);
                    end
                    3'd1: begin
                        r = a - b;
                        m_c = (a >= b);
                        s = int'($signed(a)) - int'($signed(b));
                        m_v = (s > 32767) || (s < -32768);
                    end
                    3'd2: r = a & b;
                    3'd3: r = a | b;
                    default: r = a ^ b;
                endcase
                m_n = r[DW-1];
                m_z = (r == 0);
                m_stk.push_front(r);
                e.busy  = 2;
                e.first = 3'b001;
            end
        end else if (op == 3'd5) begin
            if (m_stk.size() >= 1 && m_stk.size() < DP) m_stk.push_front(m_stk[0]);
            else ok = 0;
        end else if (op == 3'd6) begin
            if (m_stk.size() >= 2) begin
                t = m_stk[0];
                m_stk[0] = m_stk[1];
                m_stk[1] = t;
            end else ok = 0;
        end else begin
            if (m_stk.size() >= 1) void'(m_stk.pop_front());
            else ok = 0;
        end
        m_err = !ok;
        if (!ok) begin
            e.busy  = 1;
            e.first = 3'b100;
        end
        e.depth = m_stk.size();
        e.tos   = (m_stk.size() > 0) ? m_stk[0] : '0;
        e.flags = {m_n, m_z, m_c, m_v, m_err};
        return e;
    endfunction

    // Monitor: spot an accepted press, follow the DUT back to IDLE, compare
    initial begin : monitor
        logic    en_prev;
        int      busy;
        logic [2:0] first;
        logic    done;
        exp_t    e;
        logic [DW-1:0] dexp;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && Enter && !en_prev && Status == 3'b000) begin
                en_prev = Enter;
                busy  = 0;
                first = 3'b000;
                done  = 1'b0;
                for (int k = 0; k < 10 && !done; k++) begin
                    @(negedge clk);
                    if (Status == 3'b000) done = 1'b1;
                    else begin
                        if (busy == 0) first = Status;
                        busy++;
                    end
                    en_prev = Enter;
                end
                if (!done) chk("cmd_timeout", 32'(busy), 32'(0));
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(0), 32'(1));
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", 32'(busy), 32'(e.busy));
                    if (e.busy > 0) chk("first_status", 32'(first), 32'(e.first));
                    chk("depth", 32'(Depth), 32'(e.depth));
                    chk("flags", 32'(Flags), 32'(e.flags));
                    dexp = (e.depth == 0 || (!IsOp && !Enter)) ? DataIn : e.tos;
                    chk("display", 32'(ToDisplay), 32'(dexp));
                end
            end else begin
                en_prev = Enter;
            end
        end
    end

    task automatic cmd(input logic isop, input logic [2:0] op, input logic [DW-1:0] d, input int hold);
        sb.push_back(model(isop, op, d));
        @(posedge clk);
        #2;
        IsOp   = isop;
        OpCode = op;
        DataIn = d;
        Enter  = 1'b1;
        repeat (hold) @(posedge clk);
        #2 Enter = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("sb_drain", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic look();
        @(negedge clk);
        IsOp = 1'b1;
        #1;
    endtask

    initial begin : stim
        DataIn = 16'hA5A5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_depth", 32'(Depth), 32'(0));
        chk("rst_flags", 32'(Flags), 32'(0));
        chk("rst_status", 32'(Status), 32'(0));
        chk("rst_display", 32'(ToDisplay), 32'h0000A5A5);
        @(negedge clk);
        reset = 1'b0;

        cmd(0, 3'd0, 16'h0005, 1);
        cmd(0, 3'd0, 16'h0003, 1);
        cmd(1, 3'd0, 16'h0000, 1);
        look();
        chk("add_tos", 32'(ToDisplay), 32'h0008);
        chk("add_flags", 32'(Flags), 32'(5'b00000));

        cmd(1, 3'd7, 16'h0000, 1);
        cmd(0, 3'd0, 16'h7FFF, 2);
        cmd(0, 3'd0, 16'h0001, 1);
        cmd(1, 3'd0, 16'h0000, 3);
        look();
        chk("ovf_tos", 32'(ToDisplay), 32'h8000);
        chk("ovf_flags", 32'(Flags), 32'(5'b10010));

        cmd(1, 3'd7, 16'h0000, 1);
        cmd(0, 3'd0, 16'h0003, 1);
        cmd(0, 3'd0, 16'h0005, 1);
        cmd(1, 3'd1, 16'h0000, 1);
        look();
        chk("sub_tos", 32'(ToDisplay), 32'hFFFE);
        chk("sub_flags", 32'(Flags), 32'(5'b10000));
        cmd(1, 3'd5, 16'h0000, 1);
        cmd(1, 3'd4, 16'h0000, 1);
        look();
        chk("xor_tos", 32'(ToDisplay), 32'h0000);
        chk("xor_flags", 32'(Flags), 32'(5'b01000));

        cmd(1, 3'd7, 16'h0000, 1);
        for (int i = 1; i <= 5; i++) cmd(0, 3'd0, 16'(i), 1);
        look();
        chk("full_tos", 32'(ToDisplay), 32'h0004);
        chk("full_depth", 32'(Depth), 32'(4));
        chk("full_err", 32'(Flags[0]), 32'(1));
        for (int i = 0; i < 4; i++) cmd(1, 3'd7, 16'h0000, 1);
        cmd(1, 3'd0, 16'h0000, 1);
        look();
        chk("under_err", 32'(Flags[0]), 32'(1));
        chk("under_depth", 32'(Depth), 32'(0));
        cmd(0, 3'd0, 16'h1357, 20);
        look();
        chk("held_depth", 32'(Depth), 32'(1));

        for (int n = 0; n < 250; n++) begin
            logic       isop;
            logic [2:0] op;
            isop = ($urandom_range(0, 99) < 45);
            op   = 3'($urandom_range(0, 7));
            cmd(isop, op, 16'($urandom), int'($urandom_range(1, 3)));
        end

        while (m_stk.size() < 2) cmd(0, 3'd0, 16'($urandom), 1);
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        IsOp   = 1'b1;
        OpCode = 3'd0;
        Enter  = 1'b1;
        @(posedge clk);
        #2 Enter = 1'b0;
        @(negedge clk);
        chk("pre_rst_exec", 32'(Status), 32'(3'b001));
        DataIn = 16'hBEEF;
        reset  = 1'b1;
        #1;
        chk("midrst_depth", 32'(Depth), 32'(0));
        chk("midrst_flags", 32'(Flags), 32'(0));
        chk("midrst_status", 32'(Status), 32'(0));
        chk("midrst_display", 32'(ToDisplay), 32'h0000BEEF);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
